// File: rtl/instr_pkg.sv
// Shared encoding definitions for the 24-bit instruction word.
// Consumed by instr_encoder and kept in step with control_unit.
package instr_pkg;

    localparam int unsigned INSTR_W = 24;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_BR  = 2'b11;

    localparam logic [2:0] COND_AL  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_NE  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_MAX = COND_GE;

    // Reserved: the decoder treats this op as "ALU idle".
    localparam logic [5:0] ALU_IDLE = 6'b111111;

    localparam int unsigned CLS_LSB  = 22;
    localparam int unsigned COND_LSB = 12;
    localparam int unsigned RD_LSB   = 12;
    localparam int unsigned RS_LSB   = 10;
    localparam int unsigned ALU_LSB  = 4;
    localparam int unsigned IMM_LSB  = 0;

    function automatic logic is_legal(
        input logic [1:0] cls,
        input logic [5:0] alu_op,
        input logic [2:0] cond
    );
        logic ok;
        ok = 1'b1;
        if (cls == CLS_ALU && alu_op == ALU_IDLE) ok = 1'b0;
        if (cls == CLS_BR && cond > COND_MAX)     ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [1:0]  cls,
        input logic [1:0]  rd,
        input logic [1:0]  rs,
        input logic [5:0]  alu_op,
        input logic [11:0] imm,
        input logic        mem_wr,
        input logic [2:0]  cond
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[CLS_LSB +: 2] = cls;
        unique case (cls)
            CLS_ALU: begin
                w[RD_LSB +: 2]  = rd;
                w[RS_LSB +: 2]  = rs;
                w[ALU_LSB +: 6] = alu_op;
            end
            CLS_LDI: begin
                w[RD_LSB +: 2]   = rd;
                w[IMM_LSB +: 12] = imm;
            end
            CLS_MEM: begin
                // imm[11] has no slot; bit 0 carries the store flag.
                w[RD_LSB +: 2] = rd;
                w[11:1]        = imm[10:0];
                w[0]           = mem_wr;
            end
            default: begin
                w[COND_LSB +: 3] = cond;
                w[IMM_LSB +: 12] = imm;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; head entry is read straight from storage.
// Storage is cleared on reset so the head reads zero while empty after reset.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Validates and packs decoded instruction fields, queues the 24-bit words and
// streams them with sequential program addresses to the instruction memory.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_rs,
    input  logic [5:0]        in_alu_op,
    input  logic [11:0]       in_imm,
    input  logic              in_mem_wr,
    input  logic [2:0]        in_cond,
    input  logic              restart,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_code,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    logic              clr;
    logic              accept, legal, push, pop;
    logic              fifo_full, fifo_empty;
    logic [23:0]       packed_word;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // restart behaves exactly like reset and overrides any handshake.
    assign clr = rst | restart;

    assign in_ready    = !fifo_full;
    assign out_valid   = !fifo_empty;
    assign accept      = in_valid && in_ready;
    assign legal       = is_legal(in_class, in_alu_op, in_cond);
    assign push        = accept && legal;
    assign pop         = out_valid && out_ready;
    assign packed_word = pack_instr(in_class, in_rd, in_rs, in_alu_op, in_imm,
                                    in_mem_wr, in_cond);

    always_comb begin
        addr_d    = addr_q;
        err_d     = accept && !legal;
        err_cnt_d = err_cnt_q;
        if (pop) addr_d = addr_q + 1'b1;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(24)
    ) u_fifo (
        .clk  (clk),
        .rst  (clr),
        .push (push),
        .pop  (pop),
        .wdata(packed_word),
        .rdata(out_code),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; a second instance with a 2-bit address
// counter shares the stimulus to exercise address wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, restart;
    logic        in_valid, out_ready, in_mem_wr;
    logic [1:0]  in_class, in_rd, in_rs;
    logic [5:0]  in_alu_op;
    logic [11:0] in_imm;
    logic [2:0]  in_cond;

    logic        in_ready, out_valid, err_illegal;
    logic [23:0] out_code;
    logic [7:0]  out_addr, err_count;

    logic        in_ready2, out_valid2, err_illegal2;
    logic [23:0] out_code2;
    logic [1:0]  out_addr2;
    logic [7:0]  err_count2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs(in_rs), .in_alu_op(in_alu_op),
        .in_imm(in_imm), .in_mem_wr(in_mem_wr), .in_cond(in_cond), .restart(restart),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_addr(out_addr), .err_illegal(err_illegal), .err_count(err_count)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_class(in_class), .in_rd(in_rd), .in_rs(in_rs), .in_alu_op(in_alu_op),
        .in_imm(in_imm), .in_mem_wr(in_mem_wr), .in_cond(in_cond), .restart(restart),
        .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2),
        .out_addr(out_addr2), .err_illegal(err_illegal2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cls, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [5:0] alu, input logic [11:0] imm, input logic wr,
                         input logic [2:0] cond);
        in_valid  = 1'b1;
        in_class  = cls;
        in_rd     = rd;
        in_rs     = rs;
        in_alu_op = alu;
        in_imm    = imm;
        in_mem_wr = wr;
        in_cond   = cond;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_class = '0; in_rd = '0; in_rs = '0; in_alu_op = '0;
        in_imm = '0; in_mem_wr = 1'b0; in_cond = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'h0);
        chk("rst_err_illegal", 32'(err_illegal), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // 1: ALU word, one-cycle latency
        out_ready = 1'b1;
        drive(2'b00, 2'd2, 2'd1, 6'h05, 12'h000, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_code", 32'(out_code), 32'h002450);
        chk("alu_addr", 32'(out_addr), 32'd0);
        tick();
        chk("alu_popped", 32'(out_valid), 32'd0);
        chk("alu_next_addr", 32'(out_addr), 32'd1);

        // 2: load-immediate and memory
        drive(2'b01, 2'd3, 2'd0, 6'h00, 12'hABC, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("ldi_code", 32'(out_code), 32'h403ABC);
        chk("ldi_addr", 32'(out_addr), 32'd1);
        tick();
        drive(2'b10, 2'd1, 2'd0, 6'h00, 12'h0FF, 1'b1, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("mem_code", 32'(out_code), 32'h8011FF);
        chk("mem_addr", 32'(out_addr), 32'd2);
        tick();

        // 3: illegal branch condition, then a legal branch
        drive(2'b11, 2'd0, 2'd0, 6'h00, 12'h000, 1'b0, 3'b111);
        tick();
        in_valid = 1'b0;
        chk("ill_br_no_valid", 32'(out_valid), 32'd0);
        chk("ill_br_pulse", 32'(err_illegal), 32'd1);
        chk("ill_br_count", 32'(err_count), 32'd1);
        tick();
        chk("ill_br_pulse_end", 32'(err_illegal), 32'd0);
        chk("ill_br_count_hold", 32'(err_count), 32'd1);
        drive(2'b11, 2'd0, 2'd0, 6'h00, 12'h010, 1'b0, 3'b011);
        tick();
        in_valid = 1'b0;
        chk("br_code", 32'(out_code), 32'hC03010);
        chk("br_addr", 32'(out_addr), 32'd3);
        chk("br_no_err", 32'(err_illegal), 32'd0);
        tick();

        // Reserved ALU op is rejected
        drive(2'b00, 2'd1, 2'd1, 6'h3F, 12'h000, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("ill_alu_pulse", 32'(err_illegal), 32'd1);
        chk("ill_alu_count", 32'(err_count), 32'd2);
        chk("ill_alu_no_valid", 32'(out_valid), 32'd0);
        tick();

        // 4: fill with sink stalled, fifth word held
        pulse_restart();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'd0, 2'd0, 6'h00, 12'(i + 1), 1'b0, 3'd0);
            tick();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(2'b01, 2'd0, 2'd0, 6'h00, 12'h005, 1'b0, 3'd0);
        tick();
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("head_w0_code", 32'(out_code), 32'h400001);
        chk("head_w0_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("w1_code", 32'(out_code), 32'h400002);
        chk("w1_addr", 32'(out_addr), 32'd1);
        chk("w1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("w2_code", 32'(out_code), 32'h400003);
        chk("w2_addr", 32'(out_addr), 32'd2);
        tick();
        chk("w3_code", 32'(out_code), 32'h400004);
        chk("w3_addr", 32'(out_addr), 32'd3);
        tick();
        chk("w5_code", 32'(out_code), 32'h400005);
        chk("w5_addr", 32'(out_addr), 32'd4);
        tick();
        chk("drained", 32'(out_valid), 32'd0);

        // 5: 2-bit address counter wraps
        pulse_restart();
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, 2'd1, 2'd0, 6'h00, 12'(16 + k), 1'b0, 3'd0);
            tick();
            chk("wrap_addr", 32'(out_addr2), 32'(k % 4));
            chk("wrap_code", 32'(out_code2), 32'h401000 + 32'(16 + k));
        end
        in_valid = 1'b0;
        tick();

        // 6: restart with words queued and a push in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 2'd2, 2'd0, 6'h00, 12'(32 + i), 1'b0, 3'd0);
            tick();
        end
        chk("queued_valid", 32'(out_valid), 32'd1);
        drive(2'b01, 2'd2, 2'd0, 6'h00, 12'h0EE, 1'b0, 3'd0);
        restart = 1'b1;
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd0);
        chk("restart_addr", 32'(out_addr), 32'd0);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("restart_stays_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
